// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one 1-bit full-subtractor cell, LSB first, borrow held in a flop.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    , output logic           ovf
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             brw_q;
    logic [WIDTH-1:0] xs_q;
    logic [WIDTH-1:0] ys_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             done_q;

    // The shared 1-bit cell, fed from the operand LSBs and the borrow flop.
    logic             cell_a, cell_b, cell_c, cell_d, cell_br;
    logic [WIDTH-1:0] res_d;

    assign cell_a  = xs_q[0];
    assign cell_b  = ys_q[0];
    assign cell_c  = brw_q;
    assign cell_d  = cell_a ^ cell_b ^ cell_c;
    assign cell_br = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & cell_c);
    assign res_d   = {cell_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            xs_q    <= '0;
            ys_q    <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        xs_q    <= x;
                        ys_q    <= y;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    brw_q <= cell_br;
                    xs_q  <= xs_q >> 1;
                    ys_q  <= ys_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // Last bit: publish the result including the bit computed this edge.
                        diff_q  <= res_d;
                        bout_q  <= cell_br;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= cell_c ^ cell_br;
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It sequences a single 1-bit full-subtractor cell over WIDTH-bit operands, LSB first, and holds the inter-bit borrow in a flop. This trades WIDTH cycles of latency for one cell's worth of logic. It sits between a requester using a start/done handshake and the shared 1-bit subtract cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
x  input  WIDTH  minuend; latched on accepted start
y  input  WIDTH  subtrahend; latched on accepted start
bin  input  1  initial borrow-in; latched on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when result valid
diff  output  WIDTH  x - y - bin, modulo 2^WIDTH
bout  output  1  final borrow-out (1 when x < y + bin, unsigned)

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). rst_n low forces state=IDLE, counter=0, borrow flop=0, shift registers=0, diff=0, bout=0, busy=0, done=0.
- Internal 1-bit cell: d = a^b^c; br = (~a&b) | (~(a^b)&c). Here a = LSB of minuend shift register, b = LSB of subtrahend shift register, c = borrow flop.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN:
  - Transition occurs when start=1 at a clk edge.
  - Latch x and y into shift registers.
  - Borrow flop <= bin. Counter <= 0.
  - diff/bout keep their previous values until the result is written in DONE.
- RUN, on each edge:
  - Shift d into the result shift register from the MSB side (after WIDTH shifts bit 0 is at position 0).
  - Borrow flop <= br. Shift both operand registers right by 1. Counter += 1.
  - When counter == WIDTH-1 on the edge, go to DONE. RUN therefore lasts exactly WIDTH cycles.
- RUN -> DONE edge: diff <= result register (including final bit), bout <= final br, done <= 1.
- DONE: done=1 for exactly this one cycle, busy=1. Next edge goes to IDLE and done <= 0.
- Latency: start sampled at edge N; done high during cycle N+WIDTH+1 (cycle after edge N+WIDTH). diff/bout are valid from that cycle and held until the next accepted start completes.
- start is ignored in RUN and DONE: no queueing, no restart, latched operands unchanged. start held high continuously is accepted again in the first IDLE cycle, giving one operation every WIDTH+2 cycles.
- x, y, bin changes after acceptance have no effect.
- Reset asserted mid-operation aborts immediately to reset values. No done pulse is produced for the aborted operation.
- Wrap-around:
  - Arithmetic is modulo 2^WIDTH.
  - x=0, y=0, bin=1 gives diff all-ones, bout=1.
  - x=all-ones, y=0, bin=0 gives diff all-ones, bout=0.
- busy = (state != IDLE), decoded combinationally from state (registered state, glitch-free).

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined:
  - Adds output port ovf (1 bit, reset 0), the signed two's-complement overflow of x - y - bin.
  - ovf = borrow into MSB XOR borrow out of MSB, captured on the RUN -> DONE edge.
  - Held with diff.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. rst_n=0 then release, WIDTH=8 -> busy=0, done=0, diff=0x00, bout=0; start=1, x=0x05, y=0x03, bin=0 -> done pulses exactly 9 cycles after the accepting edge, diff=0x02, bout=0, busy high for 9 cycles.
2. x=0x03, y=0x05, bin=0 -> diff=0xFE, bout=1. Then x=0x00, y=0x00, bin=1 -> diff=0xFF, bout=1. Then x=0xFF, y=0x00, bin=0 -> diff=0xFF, bout=0.
3. start with x=0x10, y=0x01; in cycle 3 of RUN pulse start with x=0xAA, y=0x55 and change the inputs -> ignored; result diff=0x0F; no second done pulse.
4. start held high for 30 cycles with x=0x20, y=0x08 -> done pulses every 10 cycles, diff=0x18 each time; never two done pulses within 10 cycles.
5. Start x=0x40, y=0x01; assert rst_n low for 1 cycle at RUN cycle 4 -> all outputs return to reset values immediately; no done pulse; a fresh start afterwards completes normally with diff=0x3F.
6. With SERIAL_SUB_OVF_EN: x=0x80, y=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. x=0x7F, y=0x01 -> diff=0x7E, ovf=0. Without the macro, the port is absent and the build is clean.
